mem_access_ctrl: RTL and testbench

//  Multi-cycle sequencer for data-memory loads and stores (LW/LH/LB, SW/SH/SB).
//  - Loads: waits out memory read latency, pulses MDR load, then drives the load-size select and register write.
//  - Sub-word stores: runs read-modify-write through the store-size merge path.
//  - Word stores: single write cycle.

---
 rtl/mem_access_ctrl_pkg.sv | 50 +++++
 rtl/mem_access_ctrl_lat_counter.sv | 34 +++
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access sequencer.
// Holds the size codes (also understood by the load-size and store-size
// units), the FSM state codes, the captured-op payload and the output bundle.
package mem_access_ctrl_pkg;

  localparam int unsigned SZ_W  = 2;
  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 4;

  // Access size; the same code drives ls_ctrl / ss_ctrl directly.
  typedef enum logic [SZ_W-1:0] {
    SZ_ILL  = 2'b00,
    SZ_WORD = 2'b01,
    SZ_HALF = 2'b10,
    SZ_BYTE = 2'b11
  } size_e;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_WB    = 3'd3,
    ST_WRITE = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  // Operation captured when start is accepted.
  typedef struct packed {
    logic  is_store;
    size_e size;
  } op_t;

  // Decoded control outputs.
  typedef struct packed {
    logic            busy;
    logic            mem_wr;
    logic            mdr_load;
    logic [SZ_W-1:0] ls_ctrl;
    logic [SZ_W-1:0] ss_ctrl;
    logic            reg_wr;
    logic            done;
    logic            err;
  } ctrl_out_t;

  // Word stores skip the read phase entirely.
  function automatic logic is_word_store(input logic is_store, input logic [SZ_W-1:0] size);
    return is_store && (size == SZ_WORD);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lat_counter.sv
// Loadable 4-bit down-counter with zero flag; times the memory read wait.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   i_load      : load i_load_val (has priority over decrement)
//   i_dec       : decrement by one, saturating at zero
//   i_load_val  : value to load
//   o_zero      : count is zero
module mem_access_ctrl_lat_counter
  import mem_access_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle sequencer for data-memory loads and stores (LW/LH/LB, SW/SH/SB).
// Loads wait out the read latency, pulse MDR capture, then write back.
// Sub-word stores read, capture MDR, then write the merged word.
// Word stores write in a single cycle. Illegal size reports done+err.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : request pulse, sampled only in IDLE
//   is_store, size      : operation, captured with start
//   busy                : state != IDLE
//   mem_wr, mdr_load    : memory write / MDR capture enables
//   ls_ctrl, ss_ctrl    : load-size / store-size selects (00 when unused)
//   reg_wr              : register-file write enable
//   done, err           : completion pulse, illegal-size flag
// MEM_LAT: read latency in cycles, legal range 1..15.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [SZ_W-1:0] size,
  output logic            busy,
  output logic            mem_wr,
  output logic            mdr_load,
  output logic [SZ_W-1:0] ls_ctrl,
  output logic [SZ_W-1:0] ss_ctrl,
  output logic            reg_wr,
  output logic            done,
  output logic            err
);

  // READ lasts MEM_LAT cycles: it exits on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

  state_e    r_state;
  state_e    w_state_nxt;
  op_t       r_op;
  logic      w_capture;
  logic      w_cnt_load;
  logic      w_cnt_dec;
  logic      w_cnt_zero;
  ctrl_out_t w_out;

  mem_access_ctrl_lat_counter u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (LAT_INIT),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Captured operation; frozen for the rest of the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0;
    end else if (w_capture) begin
      r_op <= '{is_store: is_store, size: size_e'(size)};
    end
  end

  // Next-state logic and counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          if (size == SZ_ILL) begin
            w_state_nxt = ST_FAULT;
          end else if (is_word_store(is_store, size)) begin
            w_state_nxt = ST_WRITE;
          end else begin
            w_state_nxt = ST_READ;
            w_cnt_load  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_LATCH;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_LATCH: w_state_nxt = r_op.is_store ? ST_WRITE : ST_WB;
      ST_WB,
      ST_WRITE,
      ST_FAULT: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    w_out      = '0;
    w_out.busy = (r_state != ST_IDLE);
    unique case (r_state)
      ST_LATCH: w_out.mdr_load = 1'b1;
      ST_WB: begin
        w_out.reg_wr  = 1'b1;
        w_out.ls_ctrl = r_op.size;
        w_out.done    = 1'b1;
      end
      ST_WRITE: begin
        w_out.mem_wr  = 1'b1;
        w_out.ss_ctrl = r_op.size;
        w_out.done    = 1'b1;
      end
      ST_FAULT: begin
        w_out.done = 1'b1;
        w_out.err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = w_out.busy;
  assign mem_wr   = w_out.mem_wr;
  assign mdr_load = w_out.mdr_load;
  assign ls_ctrl  = w_out.ls_ctrl;
  assign ss_ctrl  = w_out.ss_ctrl;
  assign reg_wr   = w_out.reg_wr;
  assign done     = w_out.done;
  assign err      = w_out.err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; two instances (MEM_LAT=2 and 1)
// receive identical stimulus. Outputs are checked every cycle as a packed
// vector {busy,mem_wr,mdr_load,ls_ctrl,ss_ctrl,reg_wr,done,err}.
module tb_mem_access_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       is_store;
  logic [1:0] size;

  logic       busy2, mem_wr2, mdr_load2, reg_wr2, done2, err2;
  logic [1:0] ls2, ss2;
  logic       busy1, mem_wr1, mdr_load1, reg_wr1, done1, err1;
  logic [1:0] ls1, ss1;

  int checks;
  int errors;

  mem_access_ctrl #(.MEM_LAT(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .size(size),
    .busy(busy2), .mem_wr(mem_wr2), .mdr_load(mdr_load2), .ls_ctrl(ls2),
    .ss_ctrl(ss2), .reg_wr(reg_wr2), .done(done2), .err(err2)
  );

  mem_access_ctrl #(.MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .size(size),
    .busy(busy1), .mem_wr(mem_wr1), .mdr_load(mdr_load1), .ls_ctrl(ls1),
    .ss_ctrl(ss1), .reg_wr(reg_wr1), .done(done1), .err(err1)
  );

  logic [9:0] obs2, obs1;
  assign obs2 = {busy2, mem_wr2, mdr_load2, ls2, ss2, reg_wr2, done2, err2};
  assign obs1 = {busy1, mem_wr1, mdr_load1, ls1, ss1, reg_wr1, done1, err1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Expected outputs in cycle t+k for an op started at edge t.
  function automatic logic [9:0] exp_out(input int lat, input logic st,
                                         input logic [1:0] sz, input int k);
    logic [9:0] e;
    e = '0;
    if (sz == 2'b00) begin
      if (k == 1) e = 10'b1_0_0_00_00_0_1_1;
    end else if (st && sz == 2'b01) begin
      if (k == 1) e = {1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
    end else begin
      if (k >= 1 && k <= lat)  e = 10'b1_0_0_00_00_0_0_0;
      else if (k == lat + 1)   e = 10'b1_0_1_00_00_0_0_0;
      else if (k == lat + 2) begin
        if (st) e = {1'b1, 1'b1, 1'b0, 2'b00, sz, 1'b0, 1'b1, 1'b0};
        else    e = {1'b1, 1'b0, 1'b0, sz, 2'b00, 1'b1, 1'b1, 1'b0};
      end
    end
    return e;
  endfunction

  // Check both instances plus the enable exclusivity in the current cycle.
  task automatic chk_cycle(input string tag, input int k, input logic [9:0] e2,
                           input logic [9:0] e1);
    chk($sformatf("%s_l2_k%0d", tag, k), obs2, e2);
    chk($sformatf("%s_l1_k%0d", tag, k), obs1, e1);
    chk($sformatf("%s_onehot_k%0d", tag, k),
        10'($countones({mem_wr2, mdr_load2, reg_wr2}) <= 1 &&
            $countones({mem_wr1, mdr_load1, reg_wr1}) <= 1), 10'd1);
  endtask

  // Called at a negedge; launches an op this cycle and returns at the negedge
  // of the first IDLE cycle of the slower instance, so a following call
  // starts in the cycle right after done. mid_k pulses start during the op;
  // hold keeps start high through cycle k=1.
  task automatic run_op(input string tag, input logic st, input logic [1:0] sz,
                        input int mid_k, input bit hold);
    int last;
    last = (sz == 2'b00 || (st && sz == 2'b01)) ? 2 : 5;
    is_store = st;
    size     = sz;
    start    = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!hold) start = 1'b0;
        is_store = ~st;
        size     = 2'b00;
      end
      if (k == 2 && hold) start = 1'b0;
      if (k == mid_k) start = 1'b1;
      else if (k == mid_k + 1) start = 1'b0;
      chk_cycle(tag, k, exp_out(2, st, sz, k), exp_out(1, st, sz, k));
    end
    start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    is_store = 1'b0;
    size     = 2'b00;
    repeat (2) @(negedge clk);
    chk_cycle("reset", 0, '0, '0);
    reset = 1'b0;
    @(negedge clk);
    chk_cycle("idle", 0, '0, '0);

    run_op("lb", 1'b0, 2'b11, 0, 1'b0);
    run_op("sw", 1'b1, 2'b01, 0, 1'b0);
    run_op("sh_busy", 1'b1, 2'b10, 2, 1'b0);
    run_op("lw", 1'b0, 2'b01, 0, 1'b0);
    run_op("lh_busy", 1'b0, 2'b10, 3, 1'b0);
    run_op("sb", 1'b1, 2'b11, 0, 1'b0);
    run_op("ill_ld", 1'b0, 2'b00, 0, 1'b0);
    run_op("ill_st", 1'b1, 2'b00, 0, 1'b0);
    run_op("sw_hold", 1'b1, 2'b01, 0, 1'b1);

    // Reset for two cycles while both instances are in READ.
    is_store = 1'b0;
    size     = 2'b11;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_cycle("rst_pre", 1, exp_out(2, 1'b0, 2'b11, 1), exp_out(1, 1'b0, 2'b11, 1));
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_cycle("rst_hold", k, '0, '0);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_cycle("rst_after", k, '0, '0);
    end
    run_op("lb_post_rst", 1'b0, 2'b11, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
